// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 framing of one byte per write strobe, LSB first.
// busy, done and tx are registered; busy is the back-pressure to the output mux.
module uart_tx #(
    parameter int unsigned BAUD_DIV  = 434,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int unsigned CntW = $clog2(BAUD_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

    generate
        if (BAUD_DIV < 2 || BAUD_DIV > 65535 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
            $error("uart_tx: BAUD_DIV must be 2..65535 and STOP_BITS 1 or 2");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            stop_q, stop_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            bit_end;
    logic            stop_last;

    assign bit_end   = (cnt_q == CntMax);
    assign stop_last = (STOP_BITS == 2) ? stop_q : 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d  = '0;
                idx_d  = '0;
                stop_d = 1'b0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (write) begin
                    shift_d = data;
                    state_d = StStart;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                        stop_d  = 1'b0;
                        tx_d    = 1'b1;
                    end else begin
                        // tx is registered, so drive the bit that is about to become shift[0]
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (stop_last) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
